fb_writer: RTL and testbench

Downstream of the gpu pixel stage. Consumes per-pixel framebuffer writes (fb_x, fb_y, fb_color, fb_write), converts each to a linear byte address in the current back buffer, buffers them in a small FIFO, and drains them to the SRAM write port with a valid/ready handshake. Owns double buffering: a swap request flips front and back at the next vblank once all back-buffer pixels are committed.

---
 rtl/gfx_pkg.sv | 26 ++
 rtl/fbw_fifo.sv | 68 ++++++
 rtl/fb_writer.sv | 160 ++++++++++++++++
 tb/tb_fb_writer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// ============================================================================
// gfx_pkg : framebuffer geometry defaults, pixel FIFO entry and swap states
// Revision: 1.0
// ============================================================================
`default_nettype none

package gfx_pkg;

    localparam int unsigned GFX_FB_WIDTH  = 400;
    localparam int unsigned GFX_FB_HEIGHT = 240;
    localparam logic [31:0] GFX_FB0_BASE  = 32'h0000_0000;
    localparam logic [31:0] GFX_FB1_BASE  = GFX_FB0_BASE + 32'(GFX_FB_WIDTH * GFX_FB_HEIGHT * 2);

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] color;
    } pix_entry_t;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_t;

endpackage : gfx_pkg

`default_nettype wire

// File: rtl/fbw_fifo.sv
// ============================================================================
// fbw_fifo : synchronous pixel FIFO; a push while full is taken if a pop
// happens in the same cycle.  Revision: 1.0
// ============================================================================
`default_nettype none

module fbw_fifo
    import gfx_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  pix_entry_t wdata_i,
    input  logic       pop_i,
    output pix_entry_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    pix_entry_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the occupancy counter says what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule : fbw_fifo

`default_nettype wire

// File: rtl/fb_writer.sv
// ============================================================================
// fb_writer : pixel-to-SRAM write path with double-buffer swap at vblank.
// Optional FBW_STATS_EN adds frame_pixels (pops counted per frame).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fb_writer
    import gfx_pkg::*;
#(
    parameter int unsigned FB_WIDTH   = GFX_FB_WIDTH,
    parameter int unsigned FB_HEIGHT  = GFX_FB_HEIGHT,
    parameter logic [31:0] FB0_BASE   = GFX_FB0_BASE,
    parameter logic [31:0] FB1_BASE   = GFX_FB1_BASE,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fb_x,
    input  logic [15:0] fb_y,
    input  logic [15:0] fb_color,
    input  logic        fb_write,
    output logic        fifo_full,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic [31:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_write,
    input  logic        sram_ready,
    input  logic        vblank,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        swap_done,
    output logic [31:0] front_base
`ifdef FBW_STATS_EN
    ,
    output logic [31:0] frame_pixels
`endif
);

    localparam logic [31:0] C_WIDTH  = 32'(FB_WIDTH);
    localparam logic [31:0] C_HEIGHT = 32'(FB_HEIGHT);

    swap_state_t state_q, state_d;
    logic        buf_sel_q;
    logic        swap_req_q;
    logic        swap_done_q;
    logic        overflow_q, overflow_d;
    logic        swap_fire;
    logic        swap_rise;

    logic [31:0] back_base;
    logic [31:0] pix_offset;
    logic        in_bounds;
    logic        push_req;
    logic        push_acc;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full_w;
    pix_entry_t  push_entry;
    pix_entry_t  head_entry;

    assign front_base = buf_sel_q ? FB1_BASE : FB0_BASE;
    assign back_base  = buf_sel_q ? FB0_BASE : FB1_BASE;

    assign in_bounds  = (32'(fb_x) < C_WIDTH) && (32'(fb_y) < C_HEIGHT);
    assign pix_offset = (32'(fb_y) * C_WIDTH + 32'(fb_x)) << 1;
    assign push_entry = '{addr: back_base + pix_offset, color: fb_color};

    assign push_req = fb_write && in_bounds;
    assign pop      = !fifo_empty && sram_ready;
    assign push_acc = push_req && (!fifo_full_w || pop);

    fbw_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty)
    );

    // Outputs read zero while idle so the bus is quiet when nothing is queued.
    assign sram_write = !fifo_empty;
    assign sram_addr  = fifo_empty ? 32'h0 : head_entry.addr;
    assign sram_wdata = fifo_empty ? 16'h0 : head_entry.color;
    assign fifo_full  = fifo_full_w;

    assign overflow     = overflow_q;
    assign swap_pending = (state_q == ST_PENDING);
    assign swap_done    = swap_done_q;

    always_comb begin
        overflow_d = overflow_q;
        if (push_req && !push_acc) overflow_d = 1'b1;
        else if (clear_overflow)   overflow_d = 1'b0;
    end

    assign swap_rise = swap_req && !swap_req_q;

    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (swap_rise) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                // Only swap once every back-buffer pixel has left the FIFO.
                if (fifo_empty && !push_acc && vblank) begin
                    swap_fire = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            buf_sel_q   <= 1'b0;
            swap_req_q  <= 1'b0;
            swap_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_sel_q   <= buf_sel_q ^ swap_fire;
            swap_req_q  <= swap_req;
            swap_done_q <= swap_fire;
            overflow_q  <= overflow_d;
        end
    end

`ifdef FBW_STATS_EN
    logic [31:0] pix_cnt_q;
    logic [31:0] frame_pixels_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_q      <= '0;
            frame_pixels_q <= '0;
        end else if (swap_done_q) begin
            pix_cnt_q      <= pop ? 32'd1 : 32'd0;
            frame_pixels_q <= pix_cnt_q;
        end else if (pop) begin
            pix_cnt_q      <= pix_cnt_q + 32'd1;
        end
    end

    assign frame_pixels = frame_pixels_q;
`endif

endmodule : fb_writer

`default_nettype wire

// File: tb/tb_fb_writer.sv
// ============================================================================
// tb_fb_writer : table-driven directed bench for fb_writer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fb_writer;

    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0002_EE00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] fb_x, fb_y, fb_color;
    logic        fb_write, clear_overflow, sram_ready, vblank, swap_req;
    logic        fifo_full, overflow, sram_write, swap_pending, swap_done;
    logic [31:0] sram_addr, front_base;
    logic [15:0] sram_wdata;
`ifdef FBW_STATS_EN
    logic [31:0] frame_pixels;
`endif

    always #5 clk = ~clk;

    fb_writer dut (
        .clk            (clk),
        .reset          (reset),
        .fb_x           (fb_x),
        .fb_y           (fb_y),
        .fb_color       (fb_color),
        .fb_write       (fb_write),
        .fifo_full      (fifo_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_write     (sram_write),
        .sram_ready     (sram_ready),
        .vblank         (vblank),
        .swap_req       (swap_req),
        .swap_pending   (swap_pending),
        .swap_done      (swap_done),
        .front_base     (front_base)
`ifdef FBW_STATS_EN
        ,
        .frame_pixels   (frame_pixels)
`endif
    );

    typedef struct {
        logic        wr;
        logic [15:0] x, y, c;
        logic        rdy, vb, sreq, clr;
        logic        e_sw;
        logic [31:0] e_addr;
        logic [15:0] e_wd;
        logic        e_full, e_ovf, e_pend, e_done;
        logic [31:0] e_front;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic wr, input logic [15:0] x, y, c,
                       input logic rdy, vb, sreq, clr,
                       input logic e_sw, input logic [31:0] e_addr, input logic [15:0] e_wd,
                       input logic e_full, e_ovf, e_pend, e_done, input logic [31:0] e_front);
        vec_t v;
        v = '{wr, x, y, c, rdy, vb, sreq, clr, e_sw, e_addr, e_wd,
              e_full, e_ovf, e_pend, e_done, e_front};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [15:0] x, y, c,
                         input logic rdy, vb, sreq, clr);
        fb_write = wr; fb_x = x; fb_y = y; fb_color = c;
        sram_ready = rdy; vblank = vb; swap_req = sreq; clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        n_vec++;
        chk({tag, " sram_write"},   32'(sram_write),   32'(v.e_sw));
        chk({tag, " sram_addr"},    sram_addr,         v.e_addr);
        chk({tag, " sram_wdata"},   32'(sram_wdata),   32'(v.e_wd));
        chk({tag, " fifo_full"},    32'(fifo_full),    32'(v.e_full));
        chk({tag, " overflow"},     32'(overflow),     32'(v.e_ovf));
        chk({tag, " swap_pending"}, 32'(swap_pending), 32'(v.e_pend));
        chk({tag, " swap_done"},    32'(swap_done),    32'(v.e_done));
        chk({tag, " front_base"},   front_base,        v.e_front);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0;
        fb_write = 0; fb_x = 0; fb_y = 0; fb_color = 0;
        sram_ready = 0; vblank = 0; swap_req = 0; clear_overflow = 0;

        //  wr  x     y    c      rdy vb sq clr | sw addr          wd     full ovf pend done front
        add(1, 10,   2,   16'h7FFF, 1, 0, 0, 0,   1, 32'h0002_F454, 16'h7FFF, 0, 0, 0, 0, B0);
        add(0, 0,    0,   0,        1, 0, 0, 0,   0, 0,             0,        0, 0, 0, 0, B0);
        add(1, 400,  0,   16'h1234, 1, 0, 0, 0,   0, 0,             0,        0, 0, 0, 0, B0);
        add(1, 0,    240, 16'h1234, 1, 0, 0, 0,   0, 0,             0,        0, 0, 0, 0, B0);
        // Fill with sram stalled: 8 stored, 9th dropped.
        for (int i = 0; i < 9; i++)
            add(1, 16'(i), 0, 16'(16'h0100 + i), 0, 0, 0, 0,
                1, B1, 16'h0100, (i >= 7), (i == 8), 0, 0, B0);
        for (int i = 1; i < 8; i++)
            add(0, 0, 0, 0, 1, 0, 0, 0,
                1, B1 + 32'(2 * i), 16'(16'h0100 + i), 0, 1, 0, 0, B0);
        add(0, 0,    0,   0,        1, 0, 0, 0,   0, 0,             0,        0, 1, 0, 0, B0);
        add(0, 0,    0,   0,        1, 0, 0, 1,   0, 0,             0,        0, 0, 0, 0, B0);
        // Three queued pixels, then swap request with vblank high.
        add(1, 1,    0,   16'h000A, 0, 0, 0, 0,   1, B1 + 2,        16'h000A, 0, 0, 0, 0, B0);
        add(1, 2,    0,   16'h000B, 0, 0, 0, 0,   1, B1 + 2,        16'h000A, 0, 0, 0, 0, B0);
        add(1, 3,    0,   16'h000C, 0, 0, 0, 0,   1, B1 + 2,        16'h000A, 0, 0, 0, 0, B0);
        add(0, 0,    0,   0,        1, 1, 1, 0,   1, B1 + 4,        16'h000B, 0, 0, 1, 0, B0);
        add(0, 0,    0,   0,        1, 1, 1, 0,   1, B1 + 6,        16'h000C, 0, 0, 1, 0, B0);
        add(0, 0,    0,   0,        1, 1, 1, 0,   0, 0,             0,        0, 0, 1, 0, B0);
        add(0, 0,    0,   0,        1, 1, 1, 0,   0, 0,             0,        0, 0, 0, 1, B1);
        add(0, 0,    0,   0,        1, 1, 1, 0,   0, 0,             0,        0, 0, 0, 0, B1);
        add(1, 0,    0,   16'h0055, 0, 0, 0, 0,   1, 32'h0,         16'h0055, 0, 0, 0, 0, B1);
        add(0, 0,    0,   0,        1, 0, 0, 0,   0, 0,             0,        0, 0, 0, 0, B1);
        // Second request edge while pending is ignored.
        add(0, 0,    0,   0,        1, 0, 1, 0,   0, 0,             0,        0, 0, 1, 0, B1);
        add(0, 0,    0,   0,        1, 0, 0, 0,   0, 0,             0,        0, 0, 1, 0, B1);
        add(0, 0,    0,   0,        1, 0, 1, 0,   0, 0,             0,        0, 0, 1, 0, B1);
        add(0, 0,    0,   0,        1, 0, 1, 0,   0, 0,             0,        0, 0, 1, 0, B1);
        add(0, 0,    0,   0,        1, 1, 1, 0,   0, 0,             0,        0, 0, 0, 1, B0);
        add(0, 0,    0,   0,        1, 1, 1, 0,   0, 0,             0,        0, 0, 0, 0, B0);
        add(0, 0,    0,   0,        1, 1, 0, 0,   0, 0,             0,        0, 0, 0, 0, B0);

        repeat (3) @(posedge clk);
        #1;
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B0};
        check_vec("reset", v);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].x, tbl[i].y, tbl[i].c,
                  tbl[i].rdy, tbl[i].vb, tbl[i].sreq, tbl[i].clr);
            check_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Mid-operation reset with front=FB1, 4 queued pixels and a pending swap.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        n_vec++;
        chk("pre-reset front_base", front_base, B1);
        for (int i = 0; i < 4; i++)
            drive(1, 16'(i), 16'd5, 16'(16'h0200 + i), 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        n_vec++;
        chk("pre-reset swap_pending", 32'(swap_pending), 32'd1);
        chk("pre-reset sram_write",   32'(sram_write),   32'd1);
        #2;
        reset = 1'b0;
        #1;
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B0};
        check_vec("async-reset", v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0);
            n_vec++;
            chk($sformatf("post-reset%0d sram_write", i), 32'(sram_write), 32'd0);
            chk($sformatf("post-reset%0d front_base", i), front_base, B0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fb_writer

`default_nettype wire
